// File: rtl/frog_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// frog_game_ctrl_if
// Bundles the signals between the frog game sequencer and its surroundings.
// The pixel datapath, switches and frame timing drive the inputs. LEDs,
// seven-segment logic and frog-position logic consume the outputs.
//   frame_tick   one-cycle pulse per VGA frame
//   start        raw start switch level (asynchronous)
//   collide      frog overlaps a car this frame
//   goal         frog is in the goal row this frame
//   state        00 IDLE, 01 GAME_1, 10 GAME_2, 11 DONE
//   p1_score     player 1 score
//   p2_score     player 2 score
//   lives        remaining lives of the active player
//   winner       00 none, 01 P1, 10 P2, 11 tie
//   frog_respawn one-cycle pulse; reload the frog start position
//   move_en      frog movement permitted
// The master modport is the environment side. The slave modport is the
// sequencer side.
// ---------------------------------------------------------------------------
interface frog_game_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       collide;
    logic       goal;
    logic [1:0] state;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [2:0] lives;
    logic [1:0] winner;
    logic       frog_respawn;
    logic       move_en;

    modport master (
        output frame_tick, start, collide, goal,
        input  state, p1_score, p2_score, lives, winner, frog_respawn, move_en
    );

    modport slave (
        input  frame_tick, start, collide, goal,
        output state, p1_score, p2_score, lives, winner, frog_respawn, move_en
    );
endinterface

// File: rtl/frog_game_ctrl.sv
// ---------------------------------------------------------------------------
// frog_game_ctrl
// Game sequencer for the two-player frog/car game. It runs the turn order
// (P1, P2, done), keeps each player's score and lives, and issues respawn
// pulses. It also gates frog movement during the post-respawn hold.
// Ports:
//   board_clk  system clock
//   reset      asynchronous, active-high reset
//   bus        frog_game_ctrl_if.slave (frame/flag inputs, status outputs)
// Optional feature macro: FROG_TIMEOUT_EN. When defined, each life has a
// TIMEOUT_FRAMES budget of play frames. Running out counts as a collision.
// ---------------------------------------------------------------------------
module frog_game_ctrl #(
    parameter int unsigned WIN_SCORE      = 10,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned RESPAWN_FRAMES = 30,
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic             board_clk,
    input  logic             reset,
    frog_game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GAME_1 = 2'b01,
        ST_GAME_2 = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    // An out-of-range configuration keeps the game parked in IDLE.
    localparam bit CFG_OK = (WIN_SCORE >= 1) && (WIN_SCORE <= 15) &&
                            (LIVES >= 1) && (LIVES <= 7) &&
                            (RESPAWN_FRAMES >= 1) && (RESPAWN_FRAMES <= 255) &&
                            (TIMEOUT_FRAMES >= 1) && (TIMEOUT_FRAMES <= 1023);
    localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
    localparam logic [2:0] LIVES_L = 3'(LIVES);
    localparam logic [7:0] HOLD_L  = 8'(RESPAWN_FRAMES);
`ifdef FROG_TIMEOUT_EN
    localparam logic [9:0] TMO_L   = 10'(TIMEOUT_FRAMES);
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) r = 4'd15;
        else            r = v + 4'd1;
        return r;
    endfunction

    function automatic logic [1:0] calc_winner(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] w;
        if (a > b)      w = 2'b01;
        else if (b > a) w = 2'b10;
        else            w = 2'b11;
        return w;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic [2:0] lives_q, lives_d;
    logic [1:0] winner_q, winner_d;
    logic       respawn_q, respawn_d;
    logic       move_en_q, move_en_d;
    logic [7:0] hold_q, hold_d;
    logic       start_meta_q, start_sync_q, start_prev_q;
`ifdef FROG_TIMEOUT_EN
    logic [9:0] tmo_q, tmo_d;
`endif

    logic       start_rise_s;
    logic       hit_s;
    logic [3:0] new_score_s;
    logic [2:0] lives_dec_s;

    // State register, start synchroniser and all game registers
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            lives_q      <= LIVES_L;
            winner_q     <= 2'b00;
            respawn_q    <= 1'b0;
            move_en_q    <= 1'b0;
            hold_q       <= 8'd0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef FROG_TIMEOUT_EN
            tmo_q        <= 10'd0;
`endif
        end else begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            lives_q      <= lives_d;
            winner_q     <= winner_d;
            respawn_q    <= respawn_d;
            move_en_q    <= move_en_d;
            hold_q       <= hold_d;
            start_meta_q <= bus.start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
`ifdef FROG_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    // Next-state logic: turn order, scoring, lives and the hold/play phases
    always_comb begin
        state_d      = state_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        lives_d      = lives_q;
        winner_d     = winner_q;
        respawn_d    = 1'b0;
        move_en_d    = move_en_q;
        hold_d       = hold_q;
        start_rise_s = start_sync_q & ~start_prev_q;
        new_score_s  = sat_inc((state_q == ST_GAME_2) ? p2_q : p1_q);
        lives_dec_s  = (lives_q == 3'd0) ? 3'd0 : (lives_q - 3'd1);
`ifdef FROG_TIMEOUT_EN
        tmo_d        = tmo_q;
        // tmo_q is at least 1 throughout play, so reaching 1 on a frame means expiry
        hit_s        = bus.collide | (tmo_q == 10'd1);
`else
        hit_s        = bus.collide;
`endif

        case (state_q)
            ST_IDLE: begin
                move_en_d = 1'b0;
                if (start_rise_s && CFG_OK) begin
                    state_d   = ST_GAME_1;
                    p1_d      = 4'd0;
                    p2_d      = 4'd0;
                    lives_d   = LIVES_L;
                    winner_d  = 2'b00;
                    respawn_d = 1'b1;
                    hold_d    = HOLD_L;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAME_1, ST_GAME_2: begin
                if (!start_sync_q) begin
                    // Abort: scores stay visible, no respawn pulse
                    state_d   = ST_IDLE;
                    move_en_d = 1'b0;
                    hold_d    = 8'd0;
                end else if (!move_en_q) begin
                    // Hold phase: count frames down, flags are ignored
                    if (bus.frame_tick && (hold_q != 8'd0)) begin
                        hold_d = hold_q - 8'd1;
                        if (hold_q == 8'd1) begin
                            move_en_d = 1'b1;
`ifdef FROG_TIMEOUT_EN
                            tmo_d     = TMO_L;
`endif
                        end else begin
                            move_en_d = 1'b0;
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end else if (bus.frame_tick) begin
                    if (bus.goal) begin
                        if (state_q == ST_GAME_2) p2_d = new_score_s;
                        else                      p1_d = new_score_s;
                        if (new_score_s == WIN_L) begin
                            state_d   = ST_DONE;
                            move_en_d = 1'b0;
                            winner_d  = calc_winner(p1_d, p2_d);
                        end else begin
                            respawn_d = 1'b1;
                            move_en_d = 1'b0;
                            hold_d    = HOLD_L;
                        end
                    end else if (hit_s) begin
                        lives_d = lives_dec_s;
                        if (lives_q > 3'd1) begin
                            respawn_d = 1'b1;
                            move_en_d = 1'b0;
                            hold_d    = HOLD_L;
                        end else if (state_q == ST_GAME_1) begin
                            state_d   = ST_GAME_2;
                            lives_d   = LIVES_L;
                            respawn_d = 1'b1;
                            move_en_d = 1'b0;
                            hold_d    = HOLD_L;
                        end else begin
                            state_d   = ST_DONE;
                            move_en_d = 1'b0;
                            winner_d  = calc_winner(p1_q, p2_q);
                        end
                    end else begin
`ifdef FROG_TIMEOUT_EN
                        tmo_d = tmo_q - 10'd1;
`else
                        lives_d = lives_q;
`endif
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                move_en_d = 1'b0;
                if (!start_sync_q) state_d = ST_IDLE;
                else               state_d = ST_DONE;
            end
            default: begin
                state_d   = ST_IDLE;
                move_en_d = 1'b0;
            end
        endcase
    end

    // Output drive: every output comes straight from a register
    always_comb begin
        bus.state        = state_q;
        bus.p1_score     = p1_q;
        bus.p2_score     = p2_q;
        bus.lives        = lives_q;
        bus.winner       = winner_q;
        bus.frog_respawn = respawn_q;
        bus.move_en      = move_en_q;
    end
endmodule

// File: tb/tb_frog_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frog_game_ctrl
// Directed bench for frog_game_ctrl with WIN_SCORE=3, LIVES=2,
// RESPAWN_FRAMES=2, TIMEOUT_FRAMES=4. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_frog_game_ctrl;
    logic board_clk;
    logic reset;
    int   checks_cnt;
    int   errors_cnt;

    frog_game_ctrl_if bus_if ();

    frog_game_ctrl #(
        .WIN_SCORE      (3),
        .LIVES          (2),
        .RESPAWN_FRAMES (2),
        .TIMEOUT_FRAMES (4)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus_if)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks; return 1 time unit after the last rising edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge board_clk);
            #1;
        end
    endtask

    // One idle cycle, then a single frame_tick with the given flags
    task automatic frame(input logic g, input logic c);
        cyc(1);
        bus_if.frame_tick = 1'b1;
        bus_if.goal       = g;
        bus_if.collide    = c;
        cyc(1);
        bus_if.frame_tick = 1'b0;
        bus_if.goal       = 1'b0;
        bus_if.collide    = 1'b0;
    endtask

    // Two hold frames: movement stays off after the first, turns on after the second
    task automatic hold_out(input string tag);
        frame(1'b0, 1'b0);
        check_val({tag, "_hold1_move"}, 32'(bus_if.move_en), 32'd0);
        frame(1'b0, 1'b0);
        check_val({tag, "_hold2_move"}, 32'(bus_if.move_en), 32'd1);
    endtask

    // Raise start and expect GAME_1 on the third edge
    task automatic start_game(input string tag);
        bus_if.start = 1'b1;
        cyc(2);
        check_val({tag, "_state_e2"}, 32'(bus_if.state), 32'd0);
        cyc(1);
        check_val({tag, "_state_e3"}, 32'(bus_if.state), 32'd1);
        check_val({tag, "_respawn"}, 32'(bus_if.frog_respawn), 32'd1);
        check_val({tag, "_lives"}, 32'(bus_if.lives), 32'd2);
        check_val({tag, "_p1"}, 32'(bus_if.p1_score), 32'd0);
        check_val({tag, "_p2"}, 32'(bus_if.p2_score), 32'd0);
        check_val({tag, "_move"}, 32'(bus_if.move_en), 32'd0);
        cyc(1);
        check_val({tag, "_respawn_end"}, 32'(bus_if.frog_respawn), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_cnt        = 0;
        errors_cnt        = 0;
        reset             = 1'b1;
        bus_if.frame_tick = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.collide    = 1'b0;
        bus_if.goal       = 1'b0;
        cyc(3);
        check_val("rst_state", 32'(bus_if.state), 32'd0);
        check_val("rst_p1", 32'(bus_if.p1_score), 32'd0);
        check_val("rst_p2", 32'(bus_if.p2_score), 32'd0);
        check_val("rst_lives", 32'(bus_if.lives), 32'd2);
        check_val("rst_winner", 32'(bus_if.winner), 32'd0);
        check_val("rst_respawn", 32'(bus_if.frog_respawn), 32'd0);
        check_val("rst_move", 32'(bus_if.move_en), 32'd0);
        reset = 1'b0;
        cyc(2);

        // P1 scores three goals and wins outright
        start_game("g1");
        hold_out("g1a");
        frame(1'b1, 1'b0);
        check_val("goal1_p1", 32'(bus_if.p1_score), 32'd1);
        check_val("goal1_respawn", 32'(bus_if.frog_respawn), 32'd1);
        check_val("goal1_move", 32'(bus_if.move_en), 32'd0);
        hold_out("g1b");
        frame(1'b1, 1'b0);
        check_val("goal2_p1", 32'(bus_if.p1_score), 32'd2);
        hold_out("g1c");
        frame(1'b1, 1'b0);
        check_val("goal3_p1", 32'(bus_if.p1_score), 32'd3);
        check_val("goal3_state", 32'(bus_if.state), 32'd3);
        check_val("goal3_winner", 32'(bus_if.winner), 32'd1);
        check_val("goal3_move", 32'(bus_if.move_en), 32'd0);
        check_val("goal3_respawn", 32'(bus_if.frog_respawn), 32'd0);
        bus_if.start = 1'b0;
        cyc(3);
        check_val("done_idle_state", 32'(bus_if.state), 32'd0);
        check_val("done_idle_p1", 32'(bus_if.p1_score), 32'd3);
        check_val("done_idle_winner", 32'(bus_if.winner), 32'd1);

        // P1 loses both lives, P2 scores once then loses both lives
        start_game("g2");
        hold_out("g2a");
        frame(1'b0, 1'b1);
        check_val("col1_lives", 32'(bus_if.lives), 32'd1);
        check_val("col1_respawn", 32'(bus_if.frog_respawn), 32'd1);
        check_val("col1_state", 32'(bus_if.state), 32'd1);
        hold_out("g2b");
        frame(1'b0, 1'b1);
        check_val("col2_state", 32'(bus_if.state), 32'd2);
        check_val("col2_lives", 32'(bus_if.lives), 32'd2);
        check_val("col2_respawn", 32'(bus_if.frog_respawn), 32'd1);
        hold_out("g2c");
        frame(1'b1, 1'b0);
        check_val("p2goal_p2", 32'(bus_if.p2_score), 32'd1);
        hold_out("g2d");
        frame(1'b0, 1'b1);
        check_val("p2col1_lives", 32'(bus_if.lives), 32'd1);
        hold_out("g2e");
        frame(1'b0, 1'b1);
        check_val("p2col2_state", 32'(bus_if.state), 32'd3);
        check_val("p2col2_p1", 32'(bus_if.p1_score), 32'd0);
        check_val("p2col2_p2", 32'(bus_if.p2_score), 32'd1);
        check_val("p2col2_winner", 32'(bus_if.winner), 32'd2);
        check_val("p2col2_lives", 32'(bus_if.lives), 32'd0);
        check_val("p2col2_respawn", 32'(bus_if.frog_respawn), 32'd0);
        bus_if.start = 1'b0;
        cyc(3);

        // Goal and collide together, then collide during the hold phase
        start_game("g3");
        hold_out("g3a");
        frame(1'b1, 1'b1);
        check_val("both_p1", 32'(bus_if.p1_score), 32'd1);
        check_val("both_lives", 32'(bus_if.lives), 32'd2);
        frame(1'b0, 1'b1);
        check_val("holdcol1_lives", 32'(bus_if.lives), 32'd2);
        check_val("holdcol1_move", 32'(bus_if.move_en), 32'd0);
        frame(1'b0, 1'b1);
        check_val("holdcol2_lives", 32'(bus_if.lives), 32'd2);
        check_val("holdcol2_move", 32'(bus_if.move_en), 32'd1);
        frame(1'b0, 1'b1);
        check_val("g3col1_lives", 32'(bus_if.lives), 32'd1);
        hold_out("g3b");
        frame(1'b0, 1'b1);
        check_val("g3col2_state", 32'(bus_if.state), 32'd2);
        hold_out("g3c");
        frame(1'b1, 1'b0);
        check_val("g3p2_p2", 32'(bus_if.p2_score), 32'd1);

        // Abort in GAME_2: IDLE one cycle after the synchronised drop
        bus_if.start = 1'b0;
        cyc(2);
        check_val("abort_e2_state", 32'(bus_if.state), 32'd2);
        cyc(1);
        check_val("abort_state", 32'(bus_if.state), 32'd0);
        check_val("abort_p1", 32'(bus_if.p1_score), 32'd1);
        check_val("abort_p2", 32'(bus_if.p2_score), 32'd1);
        check_val("abort_move", 32'(bus_if.move_en), 32'd0);
        check_val("abort_respawn", 32'(bus_if.frog_respawn), 32'd0);
        start_game("g4");

        // Asynchronous reset mid-game, right after a respawn pulse
        hold_out("g4a");
        frame(1'b1, 1'b0);
        check_val("prerst_respawn", 32'(bus_if.frog_respawn), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_state", 32'(bus_if.state), 32'd0);
        check_val("arst_p1", 32'(bus_if.p1_score), 32'd0);
        check_val("arst_lives", 32'(bus_if.lives), 32'd2);
        check_val("arst_respawn", 32'(bus_if.frog_respawn), 32'd0);
        check_val("arst_move", 32'(bus_if.move_en), 32'd0);
        bus_if.start = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);

        // Four play frames with no flags
        start_game("g5");
        hold_out("g5a");
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check_val("tmo3_lives", 32'(bus_if.lives), 32'd2);
        frame(1'b0, 1'b0);
`ifdef FROG_TIMEOUT_EN
        check_val("tmo4_lives", 32'(bus_if.lives), 32'd1);
        check_val("tmo4_respawn", 32'(bus_if.frog_respawn), 32'd1);
`else
        check_val("tmo4_lives", 32'(bus_if.lives), 32'd2);
        check_val("tmo4_respawn", 32'(bus_if.frog_respawn), 32'd0);
`endif
        check_val("tmo4_state", 32'(bus_if.state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
- Game sequencer for the two-player frog/car VGA game.
- Each frame it samples frog-vs-car collision and frog-at-goal flags from the pixel datapath, and keeps per-player score and lives.
- Schedules the turn order: P1, then P2, then done. Issues frog respawn pulses, gates frog movement, and drives the state/score values that feed the LEDs and seven-segment display.

Parameters:
- WIN_SCORE, 10, score at which the game ends immediately (max 15).
- LIVES, 3, lives per player turn (1..7).
- RESPAWN_FRAMES, 30, frames of frozen frog after each respawn (1..255).
- TIMEOUT_FRAMES, 600, per-life frame budget; used only with FROG_TIMEOUT_EN (1..1023).

Ports:
- board_clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock board_clk
- frame_tick  in  1  one-cycle pulse per VGA frame, synchronous to board_clk
- start  in  1  raw switch level; asynchronous to board_clk
- collide  in  1  level; frog overlaps a car this frame
- goal  in  1  level; frog is in the goal row this frame
- state  out  2  00 IDLE, 01 GAME_1, 10 GAME_2, 11 DONE
- p1_score  out  4  player 1 score
- p2_score  out  4  player 2 score
- lives  out  3  remaining lives of the active player
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie; valid in DONE
- frog_respawn  out  1  one-cycle pulse; frog position must reload its start point
- move_en  out  1  frog movement permitted

Behaviour:
- Reset values: state=IDLE, scores=0, lives=LIVES, winner=00, frog_respawn=0, move_en=0, hold and timeout counters=0.
- start input:
  - Passed through a 2-flop synchroniser; rising-edge detect on the synchronised value.
  - State changes on the 3rd board_clk edge after start rises.
- IDLE:
  - On start rising edge: clear both scores, set lives=LIVES, winner=00, enter GAME_1, pulse frog_respawn.
  - Scores from the previous game remain visible in IDLE until this edge.
- GAME_x hold phase:
  - Entered on every respawn.
  - hold counter loads RESPAWN_FRAMES and decrements once per frame_tick.
  - move_en=0; collide and goal are ignored.
  - When the counter reaches 0, move_en=1 (registered, same edge).
- GAME_x play phase: evaluated only in a cycle with frame_tick=1; results registered one cycle later.
  - goal=1 takes priority over collide. Active score +1, then:
    - if the new score equals WIN_SCORE: enter DONE;
    - otherwise respawn the same player, lives unchanged.
  - collide=1 and goal=0: lives-1, then:
    - if lives>1: respawn the same player;
    - if lives was 1 in GAME_1: enter GAME_2 with lives=LIVES and respawn;
    - if lives was 1 in GAME_2: enter DONE.
  - Neither flag set: no action.
- frog_respawn: asserted exactly one cycle, coincident with the registered state/lives update.
- DONE:
  - move_en=0.
  - winner computed from the final scores: 01 if p1>p2, 10 if p2>p1, 11 if equal.
  - Returns to IDLE when synchronised start=0; scores and winner are held.
- Abort: synchronised start=0 during GAME_x enters IDLE next cycle with scores held, move_en=0, no respawn pulse.
- Scores saturate at 15; the win check must occur first, so saturation is never reached with legal parameters.
- lives never underflows below 0.
- frame_tick outside GAME_x has no effect.
- reset mid-game returns all outputs to reset values immediately (asynchronously).

Optional Feature:
- Macro: FROG_TIMEOUT_EN.
- Defined:
  - A 10-bit timeout counter loads TIMEOUT_FRAMES when the play phase begins.
  - It decrements per frame_tick during the play phase.
  - Reaching 0 with goal=0 is treated exactly as a collision.
  - goal or collide on the same frame as expiry take normal priority.
- Undefined: no timer logic; TIMEOUT_FRAMES is unused; no time limit.

Test Plan:
- Parameters for all tests: WIN_SCORE=3, LIVES=2, RESPAWN_FRAMES=2.
- Reset released, start raised -> state 00→01 on the 3rd clock edge; frog_respawn pulses once; lives=2; move_en=0 for 2 frame_ticks, then 1.
- In GAME_1 play phase, goal on 3 frames (each after its respawn hold) -> p1_score 1,2,3; after the 3rd, state=11, winner=01, move_en=0.
- GAME_1, collide twice -> lives 2→1, then state=10 with lives=2 and a respawn pulse. GAME_2 goal once, collide twice -> state=11, p1=0, p2=1, winner=10.
- goal and collide both high on one frame -> score increments, lives unchanged.
- Collide asserted during the hold phase -> ignored, lives unchanged.
- Start dropped mid GAME_2 -> IDLE next cycle, scores held. Reassert start -> scores clear to 0, state=01.
- Reset pulsed mid-game -> all outputs at reset values in the same cycle.
- With FROG_TIMEOUT_EN and TIMEOUT_FRAMES=4: no flags for 4 play frames -> lives 2→1 plus a respawn pulse. Without the macro: same stimulus -> lives stay 2.
